// File: rtl/tophat_model_loader.sv
// tophat_model_loader: byte-stream command front end for tophat_tree_core.
// Parses opcodes, unpacks model/feature payloads into the core's flattened
// vectors, issues run/clear pulses and holds off the stream while the core
// is busy.
// Optional build macro: TOPHAT_LOADER_CHECKSUM_EN appends an XOR checksum
// byte to every payload and only raises the loaded flag on a match.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_CMD   | waiting for an opcode byte
// S_MODEL | receiving the model payload (3 bytes per node, then leaves)
// S_FEAT  | receiving the feature payload (one byte per feature)
// S_CSUM  | (checksum build only) receiving the payload checksum byte
module tophat_model_loader #(
  parameter int NUM_FEATURES = 8,
  parameter int NUM_INTERNAL = 7,
  parameter int NUM_LEAVES   = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid_i,
  input  logic [7:0]                in_data_i,
  output logic                      in_ready_o,
  input  logic                      core_busy_i,
  output logic                      run_o,
  output logic                      clear_o,
  output logic                      model_loaded_o,
  output logic                      features_loaded_o,
  output logic [NUM_FEATURES*8-1:0] feature_vector_o,
  output logic [NUM_INTERNAL*3-1:0] node_feature_o,
  output logic [NUM_INTERNAL*8-1:0] node_threshold_o,
  output logic [NUM_INTERNAL*4-1:0] node_left_o,
  output logic [NUM_INTERNAL*4-1:0] node_right_o,
  output logic [NUM_LEAVES*8-1:0]   leaf_value_o,
  output logic                      err_o
);

  localparam int MODEL_BYTES = 3*NUM_INTERNAL + NUM_LEAVES;

  localparam logic [7:0] OP_LOAD_MODEL = 8'h01;
  localparam logic [7:0] OP_LOAD_FEAT  = 8'h02;
  localparam logic [7:0] OP_RUN        = 8'h03;
  localparam logic [7:0] OP_CLEAR      = 8'h04;

`ifdef TOPHAT_LOADER_CHECKSUM_EN
  typedef enum logic [1:0] {S_CMD, S_MODEL, S_FEAT, S_CSUM} state_t;
`else
  typedef enum logic [1:0] {S_CMD, S_MODEL, S_FEAT} state_t;
`endif

  state_t     state_q, state_d;
  logic [4:0] cnt_q;
  logic       accept;
  logic       run_set, clear_set;
  logic       last_model, last_feat;

`ifdef TOPHAT_LOADER_CHECKSUM_EN
  logic [7:0] xor_q;
  logic       csum_model_q;  // 1: the pending checksum belongs to a model load
`endif

  assign last_model = (cnt_q == 5'(MODEL_BYTES-1));
  assign last_feat  = (cnt_q == 5'(NUM_FEATURES-1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_CMD;
    else     state_q <= state_d;
  end

  // Next-state logic; the FSM only moves on an accepted byte
  always_comb begin
    state_d = state_q;
    if (accept) begin
      case (state_q)
        S_CMD: begin
          case (in_data_i)
            OP_LOAD_MODEL: state_d = S_MODEL;
            OP_LOAD_FEAT:  state_d = S_FEAT;
            default:       state_d = S_CMD;
          endcase
        end
`ifdef TOPHAT_LOADER_CHECKSUM_EN
        S_MODEL: if (last_model) state_d = S_CSUM;
        S_FEAT:  if (last_feat)  state_d = S_CSUM;
        S_CSUM:  state_d = S_CMD;
`else
        S_MODEL: if (last_model) state_d = S_CMD;
        S_FEAT:  if (last_feat)  state_d = S_CMD;
`endif
        default: state_d = S_CMD;
      endcase
    end
  end

  // Output logic: handshake and next-cycle pulse requests
  always_comb begin
    in_ready_o = ~core_busy_i;
    accept     = in_valid_i & ~core_busy_i;
    run_set    = accept && (state_q == S_CMD) && (in_data_i == OP_RUN);
    clear_set  = accept && (state_q == S_CMD) && (in_data_i == OP_CLEAR);
  end

  // Registered outputs, byte counter and write-through payload unpacking
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q             <= '0;
      run_o             <= 1'b0;
      clear_o           <= 1'b0;
      model_loaded_o    <= 1'b0;
      features_loaded_o <= 1'b0;
      err_o             <= 1'b0;
      feature_vector_o  <= '0;
      node_feature_o    <= '0;
      node_threshold_o  <= '0;
      node_left_o       <= '0;
      node_right_o      <= '0;
      leaf_value_o      <= '0;
`ifdef TOPHAT_LOADER_CHECKSUM_EN
      xor_q             <= '0;
      csum_model_q      <= 1'b0;
`endif
    end else begin
      run_o   <= run_set;
      clear_o <= clear_set;
      if (accept) begin
        case (state_q)
          S_CMD: begin
            case (in_data_i)
              OP_LOAD_MODEL: begin
                model_loaded_o <= 1'b0;
                cnt_q          <= '0;
`ifdef TOPHAT_LOADER_CHECKSUM_EN
                xor_q          <= '0;
                csum_model_q   <= 1'b1;
`endif
              end
              OP_LOAD_FEAT: begin
                features_loaded_o <= 1'b0;
                cnt_q             <= '0;
`ifdef TOPHAT_LOADER_CHECKSUM_EN
                xor_q             <= '0;
                csum_model_q      <= 1'b0;
`endif
              end
              OP_RUN: ;
              OP_CLEAR: begin
                model_loaded_o    <= 1'b0;
                features_loaded_o <= 1'b0;
                err_o             <= 1'b0;
                feature_vector_o  <= '0;
                node_feature_o    <= '0;
                node_threshold_o  <= '0;
                node_left_o       <= '0;
                node_right_o      <= '0;
                leaf_value_o      <= '0;
              end
              default: err_o <= 1'b1;
            endcase
          end
          S_MODEL: begin
            for (int n = 0; n < NUM_INTERNAL; n++) begin
              if (cnt_q == 5'(3*n))
                node_feature_o[n*3 +: 3] <= in_data_i[2:0];
              if (cnt_q == 5'(3*n+1))
                node_threshold_o[n*8 +: 8] <= in_data_i;
              if (cnt_q == 5'(3*n+2)) begin
                node_left_o[n*4 +: 4]  <= in_data_i[7:4];
                node_right_o[n*4 +: 4] <= in_data_i[3:0];
              end
            end
            for (int l = 0; l < NUM_LEAVES; l++) begin
              if (cnt_q == 5'(3*NUM_INTERNAL + l))
                leaf_value_o[l*8 +: 8] <= in_data_i;
            end
            cnt_q <= cnt_q + 5'd1;
`ifdef TOPHAT_LOADER_CHECKSUM_EN
            xor_q <= xor_q ^ in_data_i;
`else
            if (last_model) model_loaded_o <= 1'b1;
`endif
          end
          S_FEAT: begin
            for (int f = 0; f < NUM_FEATURES; f++) begin
              if (cnt_q == 5'(f))
                feature_vector_o[f*8 +: 8] <= in_data_i;
            end
            cnt_q <= cnt_q + 5'd1;
`ifdef TOPHAT_LOADER_CHECKSUM_EN
            xor_q <= xor_q ^ in_data_i;
`else
            if (last_feat) features_loaded_o <= 1'b1;
`endif
          end
`ifdef TOPHAT_LOADER_CHECKSUM_EN
          S_CSUM: begin
            if (in_data_i == xor_q) begin
              if (csum_model_q) model_loaded_o    <= 1'b1;
              else              features_loaded_o <= 1'b1;
            end else begin
              err_o <= 1'b1;
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

endmodule
